// File: rtl/grey_counter_gen_pkg.sv
// Shared Gray-code helpers and limits for the grey_counter_gen block.
// All helpers work on a 32-bit container and mask to the requested width.
package grey_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_WIDTH       = 32;

  function automatic logic [MAX_WIDTH-1:0] f_mask(input int width);
    if (width >= MAX_WIDTH) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] f_bin2grey(input logic [MAX_WIDTH-1:0] b,
                                                      input int width);
    return (b ^ (b >> 1)) & f_mask(width);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] f_grey2bin(input logic [MAX_WIDTH-1:0] g,
                                                      input int width);
    logic [MAX_WIDTH-1:0] gm;
    logic [MAX_WIDTH-1:0] b;
    gm = g & f_mask(width);
    b[MAX_WIDTH-1] = gm[MAX_WIDTH-1];
    for (int i = MAX_WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ gm[i];
    return b;
  endfunction

  // Next code in the increment sequence; the legacy 6-bit counter calls this with width=6.
  function automatic logic [MAX_WIDTH-1:0] f_grey_next(input logic [MAX_WIDTH-1:0] g,
                                                       input int width);
    return f_bin2grey((f_grey2bin(g, width) + 32'd1) & f_mask(width), width);
  endfunction

endpackage

// File: rtl/grey_counter_gen_if.sv
// Control and observation bundle of the Gray counter.
interface grey_counter_gen_if #(
  parameter int WIDTH = 6
) ();
  logic             incr_a;
  logic             decr_a;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] grey_o;
  logic [WIDTH-1:0] bin_o;
  logic             tc_o;
  logic             at_lim_o;
  logic             changed_o;

  modport master (
    output incr_a, decr_a, sat_mode, load, load_val,
    input  grey_o, bin_o, tc_o, at_lim_o, changed_o
  );

  modport slave (
    input  incr_a, decr_a, sat_mode, load, load_val,
    output grey_o, bin_o, tc_o, at_lim_o, changed_o
  );
endinterface

// File: rtl/grey_counter_gen_strobe_edge_sync.sv
// Synchronises one asynchronous strobe and emits a single-cycle pulse per rising edge.
// A strobe already high when reset releases must fall once before it can count.
module strobe_edge_sync
  import grey_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  output logic pulse_o
);

  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              hist_q;
  logic              armed_q;

  // fill_q marks when the last sync stage holds a genuine post-reset sample;
  // arming needs one genuine low sample so a strobe held across reset is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], a_in};
      fill_q  <= {fill_q[STAGES-2:0], 1'b1};
      hist_q  <= sync_q[STAGES-1];
      armed_q <= armed_q | (fill_q[STAGES-1] & ~sync_q[STAGES-1]);
    end
  end

  assign pulse_o = sync_q[STAGES-1] & ~hist_q & armed_q;

endmodule

// File: rtl/grey_counter_gen.sv
// Up/down Gray counter with load, wrap/saturate and async strobe inputs.
// Binary and Gray images are registered together from the same next value.
module grey_counter_gen
  import grey_pkg::*;
#(
  parameter int          WIDTH       = 6,
  parameter int          SYNC_STAGES = 3,
  parameter int unsigned RESET_VAL   = 0
) (
  input  logic               clk,
  input  logic               rst,
  grey_counter_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_BIN  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GREY = RST_BIN ^ (RST_BIN >> 1);

  logic             inc_p;
  logic             dec_p;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] grey_q, grey_d;
  logic             tc_q, tc_d;
  logic             chg_q, chg_d;

  strobe_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_incr_sync (
    .clk     (clk),
    .rst     (rst),
    .a_in    (bus.incr_a),
    .pulse_o (inc_p)
  );

  strobe_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_decr_sync (
    .clk     (clk),
    .rst     (rst),
    .a_in    (bus.decr_a),
    .pulse_o (dec_p)
  );

  // Load beats strobes; simultaneous incr/decr pulses cancel.
  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      bin_d = bus.load_val;
    end else if (inc_p && !dec_p) begin
      if (bin_q == MAX_BIN) begin
        if (!bus.sat_mode) begin
          bin_d = '0;
          tc_d  = 1'b1;
        end
      end else begin
        bin_d = bin_q + WIDTH'(1);
      end
    end else if (dec_p && !inc_p) begin
      if (bin_q == '0) begin
        if (!bus.sat_mode) begin
          bin_d = MAX_BIN;
          tc_d  = 1'b1;
        end
      end else begin
        bin_d = bin_q - WIDTH'(1);
      end
    end
    grey_d = WIDTH'(f_bin2grey(MAX_WIDTH'(bin_d), WIDTH));
    chg_d  = (grey_d != grey_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= RST_BIN;
      grey_q <= RST_GREY;
      tc_q   <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      grey_q <= grey_d;
      tc_q   <= tc_d;
      chg_q  <= chg_d;
    end
  end

  assign bus.bin_o     = bin_q;
  assign bus.grey_o    = grey_q;
  assign bus.tc_o      = tc_q;
  assign bus.changed_o = chg_q;
  assign bus.at_lim_o  = (bin_q == '0) || (bin_q == MAX_BIN);

endmodule

// File: doc/grey_counter_gen.md
Name: grey_counter_gen

Overview:
Parametrised Gray-code counter for the user project, driven by asynchronous logic-analyser strobes.
- Adds to the fixed 6-bit increment-only counter: WIDTH generalisation, up/down counting, synchronous parallel load, and a wrap/saturate mode.
- Also reports a binary image, terminal-count and change pulses.
- Sits between la_data_in/la_oenb decode and la_data_out / io_out observation bits.

Parameters:
WIDTH, 6, counter width in bits (2..32)
SYNC_STAGES, 3, synchroniser flops on each async strobe (>=2)
RESET_VAL, 0, binary value loaded at reset (must be < 2**WIDTH)

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-low reset (0 = reset)
incr_a  input  1  async increment strobe, counts on rising edge
decr_a  input  1  async decrement strobe, counts on rising edge
sat_mode  input  1  clk-domain; 1 = saturate at ends, 0 = wrap
load  input  1  clk-domain; 1-cycle synchronous load request
load_val  input  WIDTH  binary value for load
grey_o  output  WIDTH  registered Gray code of count
bin_o  output  WIDTH  registered binary count
tc_o  output  1  1-cycle pulse when a wrap occurs (either direction)
at_lim_o  output  1  level: count is 0 or 2**WIDTH-1
changed_o  output  1  1-cycle pulse in cycle after grey_o changes

Behaviour:
- Reset (rst=0, async assert):
  - bin_o=RESET_VAL; grey_o=RESET_VAL^(RESET_VAL>>1).
  - tc_o=0, changed_o=0.
  - All synchroniser and history flops cleared.
  - Deassertion is used as-is; the top level provides a synchronised deassert.
- Strobe path (per strobe):
  - SYNC_STAGES-flop chain plus one history flop.
  - Edge pulse = last sync stage & ~history.
  - A strobe first captured at clk edge k produces its count change at edge k+SYNC_STAGES.
  - A strobe held high counts exactly once.
  - A strobe high in the reset-release cycle does not count until it falls and rises again.
- Per-cycle priority, evaluated on the edge pulses:
  1. load=1: bin<=load_val. Pending strobe pulses that cycle are discarded. tc_o=0.
  2. incr pulse and decr pulse together: no change.
  3. incr pulse only:
     - bin==max, sat_mode=0: bin<=0, tc_o=1.
     - bin==max, sat_mode=1: hold, tc_o=0.
     - otherwise bin+1.
  4. decr pulse only:
     - bin==0, sat_mode=0: bin<=max, tc_o=1.
     - bin==0, sat_mode=1: hold.
     - otherwise bin-1.
- Outputs:
  - grey_o and bin_o update on the same edge; grey_o = next_bin ^ (next_bin>>1), computed before the register, with no extra latency.
  - Successive grey_o values differ in exactly one bit for any non-load step.
  - changed_o=1 for one cycle after any edge where grey_o changed, including loads of a different value; not asserted for a saturated hold.
  - at_lim_o is combinational from bin_o.
- sat_mode may change any cycle; it applies to the pulse evaluated that cycle.
- Arithmetic is WIDTH bits, unsigned; no other overflow state exists.

Decomposition:
- Package grey_pkg:
  - functions f_bin2grey(WIDTH), f_grey2bin(WIDTH), and f_grey_next, which generalises the 6-bit next-code function.
  - localparam for the minimum SYNC_STAGES.
  - Existing 6-bit users call f_grey_next with WIDTH=6.
- One sub-module, strobe_edge_sync (params SYNC_STAGES; ports clk, rst, a_in, pulse_o), instantiated twice.

Test Plan:
1. Reset with RESET_VAL=0, WIDTH=6; three incr_a rising edges 10 cycles apart:
   - grey_o sequence 0x00, 0x01, 0x03, 0x02.
   - Each change occurs 3 edges after capture; changed_o pulses 3 times.
2. load=1 with load_val=63, sat_mode=0; then one incr:
   - bin_o=63, grey_o=0x20.
   - Then bin_o=0, grey_o=0x00, tc_o high for exactly one cycle.
   - Repeat with sat_mode=1: value stays 0x20, tc_o=0, changed_o=0, at_lim_o=1.
3. From bin 0, one decr with sat_mode=0:
   - bin_o=63, grey_o=0x20, tc_o=1.
   - With sat_mode=1: holds 0, no pulses.
4. incr_a and decr_a rising in the same cycle: no change.
   - load asserted in the same cycle as an incr pulse with load_val=10: bin_o=10, grey_o=0x0F, strobe discarded.
5. incr_a held high 50 cycles: exactly one count.
   - rst pulsed low mid-sync (strobe in flight): outputs return to RESET_VAL immediately and the in-flight strobe is dropped.
6. WIDTH=8, RESET_VAL=200, SYNC_STAGES=2:
   - After reset grey_o=0xAC.
   - 56 increments wrap to 0 with a single tc_o.
   - A check on every step confirms one-bit Gray transitions and grey2bin(grey_o)==bin_o.
